// File: rtl/apb_pkg.sv
// Shared types for the queued APB master: FSM states, response codes and the
// default command record layout.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

  typedef enum logic [1:0] {
    ERR_OK  = 2'd0,
    ERR_SLV = 2'd1,
    ERR_DEC = 2'd2,
    ERR_TMO = 2'd3
  } rsp_err_e;

  typedef struct packed {
    logic                    write;
    logic [APB_ADDR_W-1:0]   addr;
    logic [APB_DATA_W-1:0]   wdata;
    logic [APB_DATA_W/8-1:0] strb;
  } apb_cmd_t;

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command FIFO in front of the APB FSM. Head is read combinationally so a
// command can be issued the cycle after it is written.
module apb_cmd_fifo
  import apb_pkg::*;
#(
  parameter int  DEPTH  = 4,
  parameter type item_t = apb_cmd_t
) (
  input  logic  PCLK,
  input  logic  PRESET,
  input  logic  push_i,
  input  item_t data_i,
  input  logic  pop_i,
  output item_t head_o,
  output logic  empty_o,
  output logic  ready_o
);

  localparam int PW    = $clog2(DEPTH);
  localparam int PTR_W = PW + 1;

  item_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_q, wr_d, rd_q, rd_d;
  logic             ready_q;
  logic             do_push, do_pop, full_d;

  assign do_push = push_i && ready_q;
  assign do_pop  = pop_i && (wr_q != rd_q);

  // Ready is registered from the next-cycle fill level, so it already
  // accounts for a same-cycle push and pop.
  always_comb begin
    wr_d   = do_push ? wr_q + PTR_W'(1) : wr_q;
    rd_d   = do_pop  ? rd_q + PTR_W'(1) : rd_q;
    full_d = (wr_d[PW] != rd_d[PW]) && (wr_d[PW-1:0] == rd_d[PW-1:0]);
  end

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      wr_q    <= '0;
      rd_q    <= '0;
      ready_q <= 1'b0;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      ready_q <= !full_d;
    end
  end

  always_ff @(posedge PCLK) begin
    if (do_push) mem_q[wr_q[PW-1:0]] <= data_i;
  end

  assign head_o  = mem_q[rd_q[PW-1:0]];
  assign empty_o = (wr_q == rd_q);
  assign ready_o = ready_q;

endmodule

// File: rtl/apb_master_queued.sv
// Queued APB master: FIFO-buffered commands issued as SETUP/ACCESS transfers
// with slave decode, wait-state timeout and one response per command.
module apb_master_queued
  import apb_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int NUM_SLV   = 4,
  parameter int SLV_SHIFT = 12,
  parameter int CMD_DEPTH = 4,
  parameter int TIMEOUT   = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_W-1:0]     cmd_addr,
  input  logic [DATA_W-1:0]     cmd_wdata,
  input  logic [DATA_W/8-1:0]   cmd_strb,
  output logic                  rsp_valid,
  output logic [DATA_W-1:0]     rsp_rdata,
  output logic [1:0]            rsp_err,
  output logic [NUM_SLV-1:0]    PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_W-1:0]     PADDR,
  output logic [DATA_W-1:0]     PWDATA,
  output logic [DATA_W/8-1:0]   PSTRB,
  input  logic [DATA_W-1:0]     PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int SW = DATA_W / 8;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [SW-1:0]     strb;
  } cmd_t;

  cmd_t               push_data, head;
  logic               fifo_empty, fifo_pop;
  logic [ADDR_W-1:0]  head_idx;
  logic [NUM_SLV-1:0] head_sel;
  logic               head_ok, timeout_hit, xfer_done;

  apb_state_e         state_q;
  logic [NUM_SLV-1:0] psel_q;
  logic               penable_q, pwrite_q;
  logic [ADDR_W-1:0]  paddr_q;
  logic [DATA_W-1:0]  pwdata_q;
  logic [SW-1:0]      pstrb_q;
  logic [CW-1:0]      wait_q;
  logic               rsp_valid_q;
  logic [DATA_W-1:0]  rsp_rdata_q;
  rsp_err_e           rsp_err_q;

  assign push_data = '{write: cmd_write, addr: cmd_addr, wdata: cmd_wdata,
                       strb: cmd_write ? cmd_strb : '0};

  apb_cmd_fifo #(.DEPTH(CMD_DEPTH), .item_t(cmd_t)) u_fifo (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .push_i  (cmd_valid),
    .data_i  (push_data),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .ready_o (cmd_ready)
  );

  assign head_idx = head.addr >> SLV_SHIFT;
  assign head_ok  = head_idx < ADDR_W'(NUM_SLV);

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_sel
    assign head_sel[gi] = (head_idx == ADDR_W'(gi));
  end

  assign timeout_hit = (TIMEOUT != 0) && (wait_q == CW'(TIMEOUT - 1));
  assign xfer_done   = (state_q == ACCESS) && (PREADY || timeout_hit);
  // A decode-error head is only consumed from IDLE, so a finishing transfer
  // falls back to IDLE and the error response follows on its own cycle.
  assign fifo_pop    = !fifo_empty && ((state_q == IDLE) || (xfer_done && head_ok));

  always_ff @(posedge PCLK) begin
    if (!PRESET) begin
      state_q     <= IDLE;
      psel_q      <= '0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      pstrb_q     <= '0;
      wait_q      <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= ERR_OK;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (!fifo_empty && head_ok) begin
            psel_q   <= head_sel;
            pwrite_q <= head.write;
            paddr_q  <= head.addr;
            pwdata_q <= head.wdata;
            pstrb_q  <= head.strb;
            state_q  <= SETUP;
          end else if (!fifo_empty) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= '0;
            rsp_err_q   <= ERR_DEC;
          end
        end
        SETUP: begin
          penable_q <= 1'b1;
          wait_q    <= '0;
          state_q   <= ACCESS;
        end
        ACCESS: begin
          if (xfer_done) begin
            rsp_valid_q <= 1'b1;
            penable_q   <= 1'b0;
            // Completion wins over a timeout landing on the same cycle.
            if (PREADY) begin
              rsp_err_q   <= PSLVERR ? ERR_SLV : ERR_OK;
              rsp_rdata_q <= (!pwrite_q && !PSLVERR) ? PRDATA : '0;
            end else begin
              rsp_err_q   <= ERR_TMO;
              rsp_rdata_q <= '0;
            end
            if (!fifo_empty && head_ok) begin
              psel_q   <= head_sel;
              pwrite_q <= head.write;
              paddr_q  <= head.addr;
              pwdata_q <= head.wdata;
              pstrb_q  <= head.strb;
              state_q  <= SETUP;
            end else begin
              psel_q  <= '0;
              state_q <= IDLE;
            end
          end else begin
            wait_q <= wait_q + CW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign PSEL      = psel_q;
  assign PENABLE   = penable_q;
  assign PWRITE    = pwrite_q;
  assign PADDR     = paddr_q;
  assign PWDATA    = pwdata_q;
  assign PSTRB     = pstrb_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
